// File: rtl/mole_scheduler.sv
// mole_scheduler: picks which mole lights and for how long from the LFSR word,
// detects player key hits, keeps score and miss counts and ends the game once
// the miss limit is reached. Every output comes straight from a register.
module mole_scheduler #(
    parameter int MOLE_BITS  = 3,
    parameter int TIMER_W    = 26,
    parameter int UP_TIME    = 50000000,
    parameter int GAP_TIME   = 25000000,
    parameter int MAX_MISSES = 5
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        play,
    input  logic [3:0]                  rnd,
    input  logic [(2**MOLE_BITS)-1:0]   keys,
    output logic [(2**MOLE_BITS)-1:0]   moles,
    output logic [7:0]                  score,
    output logic [3:0]                  misses,
    output logic                        hit_pulse,
    output logic                        miss_pulse,
    output logic                        game_over
);

    localparam int NUM_MOLES = 2**MOLE_BITS;

    // Phase lengths expressed as terminal timer values (timer counts down to 0).
    localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_TIME - 1);
    localparam logic [TIMER_W-1:0] UP_LOAD  = TIMER_W'(UP_TIME - 1);
    localparam logic [3:0]         MISS_LIM = 4'(MAX_MISSES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_UP   = 2'd2,
        S_OVER = 2'd3
    } state_t;

    // One-hot decode of a mole index.
    function automatic logic [NUM_MOLES-1:0] onehot(input logic [MOLE_BITS-1:0] idx);
        onehot = NUM_MOLES'(1) << idx;
    endfunction

    // Saturating increment for the 8-bit score.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        if (val == 8'hFF) begin
            sat_inc8 = val;
        end else begin
            sat_inc8 = val + 8'd1;
        end
    endfunction

    // Registered state
    state_t                 state_r;
    logic [TIMER_W-1:0]     timer_r;
    logic [MOLE_BITS-1:0]   last_idx_r;
    logic [NUM_MOLES-1:0]   key_prev_r;
    logic [NUM_MOLES-1:0]   moles_r;
    logic [7:0]             score_r;
    logic [3:0]             misses_r;
    logic                   hit_pulse_r;
    logic                   miss_pulse_r;
    logic                   game_over_r;

    // Next-state values
    state_t                 state_s;
    logic [TIMER_W-1:0]     timer_s;
    logic [MOLE_BITS-1:0]   last_idx_s;
    logic [NUM_MOLES-1:0]   moles_s;
    logic [7:0]             score_s;
    logic [3:0]             misses_s;
    logic                   hit_pulse_s;
    logic                   miss_pulse_s;
    logic                   game_over_s;

    // Helpers
    logic [NUM_MOLES-1:0]   key_edge_s;
    logic [NUM_MOLES-1:0]   lit_s;
    logic [MOLE_BITS-1:0]   pick_s;
    logic [3:0]             misses_inc_s;
    logic                   timer_zero_s;
    logic                   wrong_key_s;
    logic                   right_key_s;
    logic                   unused_rnd_s;

    // Only rising edges of the debounced keys count, so a held key never scores.
    assign key_edge_s   = keys & ~key_prev_r;
    assign lit_s        = onehot(last_idx_r);
    assign misses_inc_s = misses_r + 4'd1;
    assign timer_zero_s = (timer_r == {TIMER_W{1'b0}});
    assign wrong_key_s  = |(key_edge_s & ~lit_s);
    assign right_key_s  = |(key_edge_s & lit_s);
    // Upper random bits are not needed when there are fewer than 16 moles.
    assign unused_rnd_s = ^rnd;

    // Choose the next mole, bumping by one so the same mole never lights twice in a row.
    always_comb begin
        pick_s = rnd[MOLE_BITS-1:0];
        if (pick_s == last_idx_r) begin
            pick_s = pick_s + MOLE_BITS'(1);
        end else begin
            pick_s = rnd[MOLE_BITS-1:0];
        end
    end

    // Next-state and next-output logic for the game sequencer.
    always_comb begin
        state_s      = state_r;
        timer_s      = timer_r;
        last_idx_s   = last_idx_r;
        moles_s      = moles_r;
        score_s      = score_r;
        misses_s     = misses_r;
        hit_pulse_s  = 1'b0;
        miss_pulse_s = 1'b0;

        case (state_r)
            S_IDLE: begin
                moles_s = {NUM_MOLES{1'b0}};
                if (play) begin
                    score_s  = 8'd0;
                    misses_s = 4'd0;
                    timer_s  = GAP_LOAD;
                    state_s  = S_GAP;
                end else begin
                    timer_s  = {TIMER_W{1'b0}};
                end
            end

            S_GAP: begin
                if (!play) begin
                    moles_s = {NUM_MOLES{1'b0}};
                    timer_s = {TIMER_W{1'b0}};
                    state_s = S_IDLE;
                end else if (timer_zero_s) begin
                    last_idx_s = pick_s;
                    moles_s    = onehot(pick_s);
                    timer_s    = UP_LOAD;
                    state_s    = S_UP;
                end else begin
                    moles_s = {NUM_MOLES{1'b0}};
                    timer_s = timer_r - TIMER_W'(1);
                end
            end

            S_UP: begin
                if (!play) begin
                    // Abandoning a mole is neither a hit nor a miss.
                    moles_s = {NUM_MOLES{1'b0}};
                    timer_s = {TIMER_W{1'b0}};
                    state_s = S_IDLE;
                end else if (wrong_key_s || (!right_key_s && timer_zero_s)) begin
                    // A wrong key wins over a simultaneous correct key.
                    misses_s     = misses_inc_s;
                    miss_pulse_s = 1'b1;
                    moles_s      = {NUM_MOLES{1'b0}};
                    if (misses_inc_s == MISS_LIM) begin
                        timer_s = {TIMER_W{1'b0}};
                        state_s = S_OVER;
                    end else begin
                        timer_s = GAP_LOAD;
                        state_s = S_GAP;
                    end
                end else if (right_key_s) begin
                    // Includes a hit on the final lit cycle.
                    score_s     = sat_inc8(score_r);
                    hit_pulse_s = 1'b1;
                    moles_s     = {NUM_MOLES{1'b0}};
                    timer_s     = GAP_LOAD;
                    state_s     = S_GAP;
                end else begin
                    moles_s = lit_s;
                    timer_s = timer_r - TIMER_W'(1);
                end
            end

            S_OVER: begin
                moles_s = {NUM_MOLES{1'b0}};
                if (!play) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_OVER;
                end
            end

            default: begin
                moles_s = {NUM_MOLES{1'b0}};
                timer_s = {TIMER_W{1'b0}};
                state_s = S_IDLE;
            end
        endcase

        // game_over mirrors the state register so it is high exactly while in OVER.
        game_over_s = (state_s == S_OVER);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers; reset aborts a game with no pulses.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            timer_r      <= {TIMER_W{1'b0}};
            last_idx_r   <= {MOLE_BITS{1'b0}};
            key_prev_r   <= {NUM_MOLES{1'b0}};
            moles_r      <= {NUM_MOLES{1'b0}};
            score_r      <= 8'd0;
            misses_r     <= 4'd0;
            hit_pulse_r  <= 1'b0;
            miss_pulse_r <= 1'b0;
            game_over_r  <= 1'b0;
        end else begin
            timer_r      <= timer_s;
            last_idx_r   <= last_idx_s;
            key_prev_r   <= keys;
            moles_r      <= moles_s;
            score_r      <= score_s;
            misses_r     <= misses_s;
            hit_pulse_r  <= hit_pulse_s;
            miss_pulse_r <= miss_pulse_s;
            game_over_r  <= game_over_s;
        end
    end

    assign moles      = moles_r;
    assign score      = score_r;
    assign misses     = misses_r;
    assign hit_pulse  = hit_pulse_r;
    assign miss_pulse = miss_pulse_r;
    assign game_over  = game_over_r;

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: cycle-by-cycle vector table for the game flow plus a
// score saturation run, UP_TIME=8, GAP_TIME=4, MAX_MISSES=3.
module tb_mole_scheduler;

    logic       clock = 1'b0;
    logic       resetn;
    logic       play;
    logic [3:0] rnd;
    logic [7:0] keys;
    logic [7:0] moles;
    logic [7:0] score;
    logic [3:0] misses;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       game_over;

    always #5 clock = ~clock;

    mole_scheduler #(
        .MOLE_BITS  (3),
        .TIMER_W    (26),
        .UP_TIME    (8),
        .GAP_TIME   (4),
        .MAX_MISSES (3)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .play       (play),
        .rnd        (rnd),
        .keys       (keys),
        .moles      (moles),
        .score      (score),
        .misses     (misses),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .game_over  (game_over)
    );

    typedef struct packed {
        logic [7:0] moles;
        logic [7:0] score;
        logic [3:0] misses;
        logic       hit;
        logic       miss;
        logic       over;
    } out_t;

    typedef struct {
        logic       rstn;
        logic       play;
        logic [3:0] rnd;
        logic [7:0] keys;
        int         rep;
        out_t       exp;
    } vec_t;

    vec_t tbl[$];
    out_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rstn, input logic pl, input logic [3:0] r,
                                input logic [7:0] k, input int rep,
                                input logic [7:0] m, input logic [7:0] s,
                                input logic [3:0] ms, input logic h,
                                input logic mi, input logic o);
        vec_t v;
        v.rstn = rstn;
        v.play = pl;
        v.rnd  = r;
        v.keys = k;
        v.rep  = rep;
        v.exp  = {m, s, ms, h, mi, o};
        return v;
    endfunction

    task automatic check(input string name);
        out_t got;
        out_t exp;
        got = {moles, score, misses, hit_pulse, miss_pulse, game_over};
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: no expected entry queued", name);
        end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
                n_bad++;
                $display("FAIL %s: got moles=%h score=%0d misses=%0d hit=%b miss=%b over=%b, expected moles=%h score=%0d misses=%0d hit=%b miss=%b over=%b",
                         name, got.moles, got.score, got.misses, got.hit, got.miss, got.over,
                         exp.moles, exp.score, exp.misses, exp.hit, exp.miss, exp.over);
            end
        end
    endtask

    initial begin
        int  exp_score;
        bit  seen;

        resetn = 1'b0;
        play   = 1'b0;
        rnd    = 4'h0;
        keys   = 8'h00;

        //            rstn play rnd   keys   rep moles  score misses hit miss over
        tbl.push_back(mk(1'b0, 1'b0, 4'h0, 8'h00, 2, 8'h00, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0)); // reset
        tbl.push_back(mk(1'b1, 1'b0, 4'h0, 8'h00, 2, 8'h00, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0)); // idle
        tbl.push_back(mk(1'b1, 1'b1, 4'h5, 8'h00, 4, 8'h00, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0)); // gap
        tbl.push_back(mk(1'b1, 1'b1, 4'h5, 8'h00, 3, 8'h20, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0)); // mole 5
        tbl.push_back(mk(1'b1, 1'b1, 4'h5, 8'h20, 1, 8'h00, 8'd1, 4'd0, 1'b1, 1'b0, 1'b0)); // hit 3rd cycle
        tbl.push_back(mk(1'b1, 1'b1, 4'h5, 8'h00, 3, 8'h00, 8'd1, 4'd0, 1'b0, 1'b0, 1'b0)); // gap
        tbl.push_back(mk(1'b1, 1'b1, 4'h5, 8'h00, 8, 8'h40, 8'd1, 4'd0, 1'b0, 1'b0, 1'b0)); // no repeat: 6
        tbl.push_back(mk(1'b1, 1'b1, 4'h5, 8'h00, 1, 8'h00, 8'd1, 4'd1, 1'b0, 1'b1, 1'b0)); // timeout 1
        tbl.push_back(mk(1'b1, 1'b1, 4'h2, 8'h04, 3, 8'h00, 8'd1, 4'd1, 1'b0, 1'b0, 1'b0)); // key 2 held
        tbl.push_back(mk(1'b1, 1'b1, 4'h2, 8'h04, 2, 8'h04, 8'd1, 4'd1, 1'b0, 1'b0, 1'b0)); // held: no hit
        tbl.push_back(mk(1'b1, 1'b1, 4'h2, 8'h00, 1, 8'h04, 8'd1, 4'd1, 1'b0, 1'b0, 1'b0)); // release
        tbl.push_back(mk(1'b1, 1'b1, 4'h2, 8'h04, 1, 8'h00, 8'd2, 4'd1, 1'b1, 1'b0, 1'b0)); // press: hit
        tbl.push_back(mk(1'b1, 1'b1, 4'h2, 8'h00, 3, 8'h00, 8'd2, 4'd1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 4'h2, 8'h00, 8, 8'h08, 8'd2, 4'd1, 1'b0, 1'b0, 1'b0)); // 2 -> 3
        tbl.push_back(mk(1'b1, 1'b1, 4'h2, 8'h00, 1, 8'h00, 8'd2, 4'd2, 1'b0, 1'b1, 1'b0)); // timeout 2
        tbl.push_back(mk(1'b1, 1'b1, 4'h2, 8'h00, 3, 8'h00, 8'd2, 4'd2, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 4'h2, 8'h00, 8, 8'h04, 8'd2, 4'd2, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 4'h2, 8'h00, 1, 8'h00, 8'd2, 4'd3, 1'b0, 1'b1, 1'b1)); // timeout 3
        tbl.push_back(mk(1'b1, 1'b1, 4'h2, 8'h00, 3, 8'h00, 8'd2, 4'd3, 1'b0, 1'b0, 1'b1)); // over held
        tbl.push_back(mk(1'b1, 1'b0, 4'h2, 8'h00, 2, 8'h00, 8'd2, 4'd3, 1'b0, 1'b0, 1'b0)); // leave over
        tbl.push_back(mk(1'b1, 1'b1, 4'h6, 8'h00, 4, 8'h00, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0)); // restart clears
        tbl.push_back(mk(1'b1, 1'b1, 4'h6, 8'h00, 1, 8'h40, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 4'h6, 8'h42, 1, 8'h00, 8'd0, 4'd1, 1'b0, 1'b1, 1'b0)); // lit+wrong
        tbl.push_back(mk(1'b1, 1'b1, 4'h6, 8'h00, 3, 8'h00, 8'd0, 4'd1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 4'h6, 8'h00, 1, 8'h80, 8'd0, 4'd1, 1'b0, 1'b0, 1'b0)); // 6 -> 7
        tbl.push_back(mk(1'b1, 1'b1, 4'h6, 8'h80, 1, 8'h00, 8'd1, 4'd1, 1'b1, 1'b0, 1'b0)); // first-cycle hit
        tbl.push_back(mk(1'b1, 1'b1, 4'h6, 8'h00, 3, 8'h00, 8'd1, 4'd1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 4'h6, 8'h00, 2, 8'h40, 8'd1, 4'd1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 4'h6, 8'h00, 2, 8'h00, 8'd1, 4'd1, 1'b0, 1'b0, 1'b0)); // play=0 mid-UP
        tbl.push_back(mk(1'b1, 1'b1, 4'h0, 8'h00, 4, 8'h00, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 4'h0, 8'h00, 8, 8'h01, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 4'h0, 8'h01, 1, 8'h00, 8'd1, 4'd0, 1'b1, 1'b0, 1'b0)); // hit at timer 0
        tbl.push_back(mk(1'b0, 1'b1, 4'h0, 8'h00, 1, 8'h00, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0)); // reset mid-game
        tbl.push_back(mk(1'b1, 1'b0, 4'h0, 8'h00, 1, 8'h00, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                @(negedge clock);
                resetn = tbl[i].rstn;
                play   = tbl[i].play;
                rnd    = tbl[i].rnd;
                keys   = tbl[i].keys;
                sb.push_back(tbl[i].exp);
                @(posedge clock);
                #1;
                check($sformatf("row%0d.%0d", i, r));
            end
        end

        // Score saturation: hit every mole until the score has pinned at 255.
        exp_score = 0;
        @(negedge clock);
        play = 1'b1;
        keys = 8'h00;
        for (int n = 0; n < 258; n++) begin
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clock);
                rnd = 4'($urandom_range(0, 15));
                @(posedge clock);
                #1;
                if (moles != 8'h00) begin
                    seen = 1'b1;
                end
            end
            if (!seen) begin
                n_vec++;
                n_bad++;
                $display("FAIL sat_wait%0d: got no mole within 20 cycles, expected one", n);
                break;
            end
            @(negedge clock);
            keys = moles;
            exp_score = (exp_score == 255) ? 255 : exp_score + 1;
            sb.push_back({8'h00, 8'(exp_score), 4'd0, 1'b1, 1'b0, 1'b0});
            @(posedge clock);
            #1;
            check($sformatf("sat%0d", n));
            @(negedge clock);
            keys = 8'h00;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
